gate_direction_detector: RTL and testbench
==========================================

// Module: gate_direction_detector
// PURPOSE
// - Upstream stage of the parking occupancy counter.
// - Reads two raw beam-break sensors at the gate: A (outer) and B (inner).
// - Debounces both sensors and tracks the A/B blocking sequence in an FSM.
// - Emits single-cycle car_enter / car_exit pulses that drive the counter directly.
// - Runs on the same (divided) clk as the counter: one pulse = one counted event.
// PARAMETERS
// - DEB_CYCLES      4     consecutive stable samples before a debounced level changes (>=1)
// - TIMEOUT_CYCLES  2000  max cycles the FSM may stay outside IDLE (used only with GATE_TIMEOUT_EN)
// PORTS
// - clk        in   1  block clock; same divided clock as the downstream counter
// - reset      in   1  asynchronous, active-high
// - sensor_a   in   1  raw outer sensor, asynchronous; 1 = beam blocked
// - sensor_b   in   1  raw inner sensor, asynchronous; 1 = beam blocked
// - car_enter  out  1  1-cycle pulse: complete entry sequence seen
// - car_exit   out  1  1-cycle pulse: complete exit sequence seen
// - busy       out  1  FSM not in IDLE
// - seq_error  out  1  1-cycle pulse: illegal sensor transition (or timeout)
// BEHAVIOUR
// - Reset: all outputs 0; synchronisers 0; debounced a/b 0; counters 0; FSM = IDLE.
// - Input path: 2-flop synchroniser, then debounce counter per sensor.
//   - Debounced level changes only after DEB_CYCLES consecutive samples that differ
//     from the current level.
//   - A matching sample clears the counter.
//   - Raw-edge to debounced-edge latency = 2 + DEB_CYCLES cycles.
// - FSM input is {a,b} debounced. States and legal moves:
//   - IDLE(00): 10 -> EN1; 01 -> EX1.
//   - EN1(10): 11 -> EN2; 00 -> IDLE (backed off, no pulse).
//   - EN2(11): 01 -> EN3; 10 -> EN1.
//   - EN3(01): 00 -> IDLE + car_enter; 11 -> EN2.
//   - EX1(01): 11 -> EX2; 00 -> IDLE.
//   - EX2(11): 10 -> EX3; 01 -> EX1.
//   - EX3(10): 00 -> IDLE + car_exit; 11 -> EX2.
//   - Unchanged input: stay in the current state.
//   - Any other move (both bits change in one cycle): seq_error pulse, go to CLEAR.
//   - CLEAR: wait for 00, then go to IDLE with no count pulse.
// - Pulses are registered: asserted the cycle after the FSM sees 00.
//   - car_enter and car_exit are never both 1.
//   - Each asserts for exactly 1 cycle per vehicle.
// - busy = (state != IDLE), registered with the state.
// - Reset mid-sequence: return to IDLE immediately, no pulse; a partial vehicle is discarded.
// - The counter's full/empty saturation is not handled here; pulses are issued regardless.
// CONFIGURATION
// - GATE_TIMEOUT_EN defined:
//   - A cycle counter runs while state != IDLE and restarts on every state change.
//   - If it reaches TIMEOUT_CYCLES: seq_error pulse, go to CLEAR.
// - GATE_TIMEOUT_EN undefined:
//   - No counter logic is built; a stalled vehicle holds the FSM indefinitely.
// STRUCTURE
// - Package gate_pkg:
//   - gate_state_t enum {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, CLEAR}.
//   - Sensor-code localparams S_NONE=2'b00, S_A=2'b10, S_B=2'b01, S_AB=2'b11.
// - Sub-module sensor_debounce (sync + debounce, parameter DEB_CYCLES), instantiated
//   twice (a, b).
// - FSM and pulse registers live in the top module.
// TESTING
// - Entry: a=1 hold 10 cyc; b=1 hold 10; a=0 hold 10; b=0
//   -> exactly one car_enter pulse, 2+DEB_CYCLES cycles after b falls plus 1 for the register; busy then 0.
// - Exit: b, then a, then b off, then a off (10 cyc each)
//   -> one car_exit pulse; car_enter stays 0.
// - Back-off: a=1 10 cyc, a=0 -> no pulses, busy returns 0.
//   - Partial enter to EN3, back to 11, forward to 00 -> exactly 1 car_enter.
// - Bounce: toggle sensor_a every cycle for 3 cycles (< DEB_CYCLES) -> FSM stays IDLE, no outputs.
// - Illegal: force a and b 0->1 on the same edge -> seq_error 1 cycle, FSM in CLEAR.
//   - Release both -> IDLE with no count pulse.
// - Reset: assert reset while in EN2 -> outputs 0 at once; after release, an idle gate gives no pulse.
//   - With GATE_TIMEOUT_EN, TIMEOUT_CYCLES=50: hold a=1 for 100 cyc -> seq_error, then CLEAR.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared types for the gate direction detector.
// Contents: FSM state enum, debounced sensor codes {a,b}, registered pulse payload.
package gate_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN1   = 3'd1,
        EN2   = 3'd2,
        EN3   = 3'd3,
        EX1   = 3'd4,
        EX2   = 3'd5,
        EX3   = 3'd6,
        CLEAR = 3'd7
    } gate_state_t;

    // Debounced sensor codes, ordered {a, b}
    localparam logic [1:0] S_NONE = 2'b00;
    localparam logic [1:0] S_A    = 2'b10;
    localparam logic [1:0] S_B    = 2'b01;
    localparam logic [1:0] S_AB   = 2'b11;

    // One-cycle event pulses produced by the FSM
    typedef struct packed {
        logic car_enter;
        logic car_exit;
        logic seq_error;
    } gate_pulse_t;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability debouncer for one beam sensor.
// Ports:
//   clk    in  block clock
//   reset  in  asynchronous, active-high
//   raw    in  asynchronous raw sensor (1 = beam blocked)
//   level  out debounced level; follows raw only after DEB_CYCLES
//              consecutive synchronised samples that differ from it
module sensor_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronise, then count consecutive samples disagreeing with the current level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gate_direction_detector.sv
// Parking gate direction detector: debounces the outer (A) and inner (B) beam
// sensors and follows the blocking sequence to emit one pulse per vehicle.
// Optional feature macro: GATE_TIMEOUT_EN (FSM dwell timeout -> seq_error, CLEAR).
// Ports:
//   clk        in  block clock (same divided clock as the occupancy counter)
//   reset      in  asynchronous, active-high
//   sensor_a   in  raw outer sensor, asynchronous, 1 = blocked
//   sensor_b   in  raw inner sensor, asynchronous, 1 = blocked
//   car_enter  out 1-cycle pulse, complete entry sequence
//   car_exit   out 1-cycle pulse, complete exit sequence
//   busy       out FSM not in IDLE
//   seq_error  out 1-cycle pulse, illegal transition (or timeout)
module gate_direction_detector
    import gate_pkg::*;
#(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic car_enter,
    output logic car_exit,
    output logic busy,
    output logic seq_error
);

    logic        deb_a;
    logic        deb_b;
    logic [1:0]  code;

    gate_state_t state;
    gate_state_t state_next;
    gate_pulse_t pulse_r;
    gate_pulse_t pulse_next;
    logic        bad_move;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_a),
        .level (deb_a)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_b),
        .level (deb_b)
    );

    assign code = {deb_a, deb_b};

`ifdef GATE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_fire;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pulse_r <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_next;
            pulse_r <= pulse_next;
            busy    <= (state_next != IDLE);
        end
    end

    // Next state: each state has one forward and one backward single-bit move;
    // any other code change (both bits at once) is illegal
    always_comb begin
        state_next = state;
        pulse_next = '0;
        bad_move   = 1'b0;
`ifdef GATE_TIMEOUT_EN
        tmo_fire   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (code == S_A)            state_next = EN1;
                else if (code == S_B)       state_next = EX1;
                else if (code != S_NONE)    bad_move   = 1'b1;
            end
            EN1: begin
                if (code == S_AB)           state_next = EN2;
                else if (code == S_NONE)    state_next = IDLE;
                else if (code != S_A)       bad_move   = 1'b1;
            end
            EN2: begin
                if (code == S_B)            state_next = EN3;
                else if (code == S_A)       state_next = EN1;
                else if (code != S_AB)      bad_move   = 1'b1;
            end
            EN3: begin
                if (code == S_NONE) begin
                    state_next           = IDLE;
                    pulse_next.car_enter = 1'b1;
                end
                else if (code == S_AB)      state_next = EN2;
                else if (code != S_B)       bad_move   = 1'b1;
            end
            EX1: begin
                if (code == S_AB)           state_next = EX2;
                else if (code == S_NONE)    state_next = IDLE;
                else if (code != S_B)       bad_move   = 1'b1;
            end
            EX2: begin
                if (code == S_A)            state_next = EX3;
                else if (code == S_B)       state_next = EX1;
                else if (code != S_AB)      bad_move   = 1'b1;
            end
            EX3: begin
                if (code == S_NONE) begin
                    state_next          = IDLE;
                    pulse_next.car_exit = 1'b1;
                end
                else if (code == S_AB)      state_next = EX2;
                else if (code != S_A)       bad_move   = 1'b1;
            end
            CLEAR: begin
                if (code == S_NONE)         state_next = IDLE;
            end
            default:                        state_next = IDLE;
        endcase

        if (bad_move) begin
            state_next           = CLEAR;
            pulse_next.seq_error = 1'b1;
        end

`ifdef GATE_TIMEOUT_EN
        // Timeout only applies when the FSM would otherwise stay put
        if ((state != IDLE) && (state_next == state) &&
            (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))) begin
            tmo_fire             = 1'b1;
            state_next           = CLEAR;
            pulse_next.seq_error = 1'b1;
        end
`endif
    end

`ifdef GATE_TIMEOUT_EN
    // Dwell counter: restarts on any state change, in IDLE, and after firing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if ((state == IDLE) || (state_next != state) || tmo_fire) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    assign car_enter = pulse_r.car_enter;
    assign car_exit  = pulse_r.car_exit;
    assign seq_error = pulse_r.seq_error;

endmodule

// File: tb/tb_gate_direction_detector.sv
// Self-checking bench for gate_direction_detector: directed gate scenarios plus
// randomized sensor activity, scored against a sequence-level reference model.
module tb_gate_direction_detector;

    localparam int unsigned DEB = 4;
`ifdef GATE_TIMEOUT_EN
    localparam int unsigned TMO = 50;
`else
    localparam int unsigned TMO = 2000;
`endif

    localparam int EV_ENTER = 1;
    localparam int EV_EXIT  = 2;
    localparam int EV_ERR   = 4;

    logic clk = 1'b0;
    logic reset;
    logic sensor_a;
    logic sensor_b;
    logic car_enter;
    logic car_exit;
    logic busy;
    logic seq_error;

    gate_direction_detector #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .car_enter (car_enter),
        .car_exit  (car_exit),
        .busy      (busy),
        .seq_error (seq_error)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    // Reference model state: debounced levels, raw sample history,
    // and position along an entry or exit sequence
    bit m_lvl_a, m_lvl_b;
    bit hist_a[$], hist_b[$];
    int m_dir;   // 0 idle, 1 entering, 2 exiting, 3 clearing after error
    int m_pos;   // step index along the sequence (1..3)
    int m_dwell;
    bit m_busy;

    int n_enter = 0, n_exit = 0, n_err = 0;
    int last_enter_cyc = -1;

    // Codes visited by a vehicle: entry 00,10,11,01,00 ; exit 00,01,11,10,00
    function automatic logic [1:0] seq_code(int dir, int pos);
        logic [1:0] c;
        c = 2'b00;
        if (dir == 1) begin
            case (pos % 4)
                1: c = 2'b10;
                2: c = 2'b11;
                3: c = 2'b01;
                default: c = 2'b00;
            endcase
        end else begin
            case (pos % 4)
                1: c = 2'b01;
                2: c = 2'b11;
                3: c = 2'b10;
                default: c = 2'b00;
            endcase
        end
        return c;
    endfunction

    // The debounced level becomes v once the last DEB synchronised samples
    // (raw delayed by two) all equal v
    function automatic bit settled(bit h[$], bit v);
        for (int i = 0; i < int'(DEB); i++)
            if (h[h.size() - 3 - i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_lvl_a = 1'b0;
        m_lvl_b = 1'b0;
        m_dir   = 0;
        m_pos   = 0;
        m_dwell = 0;
        m_busy  = 1'b0;
        hist_a.delete();
        hist_b.delete();
        for (int i = 0; i < int'(DEB) + 2; i++) begin
            hist_a.push_back(1'b0);
            hist_b.push_back(1'b0);
        end
    endtask

    always @(posedge clk) begin
        logic [1:0] c;
        int ev;
        bit moved;
        cyc = cyc + 1;
        if (reset) begin
            model_reset();
        end else begin
            c = {m_lvl_a, m_lvl_b};
            ev = 0;
            moved = 1'b0;
            if (m_dir == 3) begin
                if (c == 2'b00) begin m_dir = 0; moved = 1'b1; end
            end else if (m_dir == 0) begin
                if (c != 2'b00) begin
                    moved = 1'b1;
                    if (c == seq_code(1, 1))      begin m_dir = 1; m_pos = 1; end
                    else if (c == seq_code(2, 1)) begin m_dir = 2; m_pos = 1; end
                    else begin m_dir = 3; ev = EV_ERR; end
                end
            end else if (c != seq_code(m_dir, m_pos)) begin
                moved = 1'b1;
                if (c == seq_code(m_dir, m_pos + 1)) begin
                    if (m_pos == 3) begin
                        ev = (m_dir == 1) ? EV_ENTER : EV_EXIT;
                        m_dir = 0;
                    end else m_pos = m_pos + 1;
                end else if (c == seq_code(m_dir, m_pos - 1)) begin
                    if (m_pos == 1) m_dir = 0;
                    else m_pos = m_pos - 1;
                end else begin
                    m_dir = 3;
                    ev = EV_ERR;
                end
            end
`ifdef GATE_TIMEOUT_EN
            if (moved || m_dir == 0) m_dwell = 0;
            else begin
                m_dwell = m_dwell + 1;
                if (m_dwell == int'(TMO)) begin
                    m_dwell = 0;
                    m_dir = 3;
                    ev = EV_ERR;
                end
            end
`else
            if (moved) m_dwell = 0;
`endif
            if (ev != 0) exp_q.push_back('{ev, cyc});
            m_busy = (m_dir != 0);

            hist_a.push_back(sensor_a);
            hist_b.push_back(sensor_b);
            if (settled(hist_a, ~m_lvl_a)) m_lvl_a = ~m_lvl_a;
            if (settled(hist_b, ~m_lvl_b)) m_lvl_b = ~m_lvl_b;
            void'(hist_a.pop_front());
            void'(hist_b.pop_front());
        end
    end

    task automatic check(string name, int got, int expv);
        vectors = vectors + 1;
        if (got != expv) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Monitor: compare busy every cycle, pop the scoreboard on each pulse
    always @(negedge clk) begin
        int got;
        ev_t e;
        if (reset) begin
            check("reset_outputs", {car_enter, car_exit, busy, seq_error}, 0);
        end else begin
            check("busy", busy, m_busy);
            if (car_enter && car_exit) check("enter_exit_exclusive", 1, 0);
            got = {29'd0, seq_error, car_exit, car_enter};
            if (got != 0) begin
                if (car_enter) begin n_enter++; last_enter_cyc = cyc; end
                if (car_exit)  n_exit++;
                if (seq_error) n_err++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", got, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", got, e.kind);
                    check("pulse_cycle", cyc, e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("missed_pulse", 0, e.kind);
            end
        end
    end

    task automatic drive(bit a, bit b, int n);
        sensor_a = a;
        sensor_b = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0, x0, r0, tfall;
        reset    = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 2);
        check("post_reset_busy", busy, 0);
        check("post_reset_pulses", {car_enter, car_exit, seq_error}, 0);

        // Entry with latency check on the final beam release
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        drive(1, 0, 10);
        drive(1, 1, 10);
        drive(0, 1, 10);
        tfall = cyc;
        drive(0, 0, 20);
        check("entry_count", n_enter - e0, 1);
        check("entry_no_exit", n_exit - x0, 0);
        check("entry_latency", last_enter_cyc, tfall + int'(DEB) + 3);
        check("entry_busy_after", busy, 0);

        // Exit
        e0 = n_enter; x0 = n_exit;
        drive(0, 1, 10);
        drive(1, 1, 10);
        drive(1, 0, 10);
        drive(0, 0, 20);
        check("exit_count", n_exit - x0, 1);
        check("exit_no_enter", n_enter - e0, 0);

        // Back-off from EN1
        e0 = n_enter; x0 = n_exit;
        drive(1, 0, 10);
        drive(0, 0, 20);
        check("backoff_pulses", (n_enter - e0) + (n_exit - x0), 0);
        check("backoff_busy", busy, 0);

        // Partial entry: reach EN3, step back to EN2, then finish
        e0 = n_enter;
        drive(1, 0, 10);
        drive(1, 1, 10);
        drive(0, 1, 10);
        drive(1, 1, 10);
        drive(0, 1, 10);
        drive(0, 0, 20);
        check("partial_entry_count", n_enter - e0, 1);

        // Bounce shorter than the debounce window
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        drive(1, 0, 1);
        drive(0, 0, 1);
        drive(1, 0, 1);
        drive(0, 0, 20);
        check("bounce_pulses", (n_enter - e0) + (n_exit - x0) + (n_err - r0), 0);

        // Both beams change on the same edge
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        drive(1, 1, 10);
        check("illegal_error", n_err - r0, 1);
        check("illegal_clear_busy", busy, 1);
        drive(0, 0, 20);
        check("illegal_no_count", (n_enter - e0) + (n_exit - x0), 0);
        check("illegal_idle", busy, 0);

        // Reset while in EN2
        drive(1, 0, 10);
        drive(1, 1, 10);
        check("en2_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("reset_mid_busy", busy, 0);
        check("reset_mid_pulses", {car_enter, car_exit, seq_error}, 0);
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        e0 = n_enter; x0 = n_exit; r0 = n_err;
        drive(0, 0, 20);
        check("after_reset_idle", (n_enter - e0) + (n_exit - x0) + (n_err - r0), 0);

`ifdef GATE_TIMEOUT_EN
        r0 = n_err;
        drive(1, 0, 100);
        check("timeout_error", int'((n_err - r0) >= 1), 1);
        drive(0, 0, 30);
        check("timeout_recovered", busy, 0);
`endif

        // Randomized sensor activity
        for (int i = 0; i < 300; i++) begin
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            drive(c[1], c[0], int'($urandom_range(1, 12)));
        end
        drive(0, 0, 40);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
